alu_result_fifo: RTL and testbench

Downstream capture stage for the 4-bit, four-function ALU (add 00, sub 01, AND 10, XOR 11).
- Each cycle the block accepts one ALU result with its carry and overflow bits, plus the 2-bit function code that produced it.
- It derives the N/Z/C/V status flags and buffers result+flags in a small FIFO.
- It presents the entries to the write-back/display consumer through a valid/ready handshake.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_flag_gen.sv | 23 ++
 rtl/alu_result_fifo.sv | 101 ++++++++++
 tb/tb_alu_result_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, status flag bit positions and the
// result+flags entry type used by the capture FIFO and the TRISC status logic.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ALU_DW = 4;

    typedef struct packed {
        logic [ALU_DW-1:0] r;
        logic [3:0]        flags;
    } alu_entry_t;

    function automatic logic is_logic_op(input logic [1:0] op);
        return (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from an ALU result and the op that made it.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [DW-1:0] r,
    input  logic          cout,
    input  logic          ovr,
    input  logic [1:0]    op,
    output logic [3:0]    flags
);

    // Logic ops have no meaningful carry or overflow, so those bits are forced low.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = r[DW-1];
        flags[FLAG_Z] = (r == '0);
        flags[FLAG_C] = is_logic_op(op) ? 1'b0 : cout;
        flags[FLAG_V] = is_logic_op(op) ? 1'b0 : ovr;
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results with status flags, valid/ready on both sides.
// Define ALU_RESULT_FIFO_BYPASS_EN for a zero-latency path when the FIFO is empty.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_r,
    input  logic                     in_cout,
    input  logic                     in_ovr,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_r,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_push_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [3:0]    f_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    in_flags;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;

    alu_flag_gen #(.DW(DW)) u_flag_gen (
        .r     (in_r),
        .cout  (in_cout),
        .ovr   (in_ovr),
        .op    (in_op),
        .flags (in_flags)
    );

    assign empty    = (count == '0);
    assign in_ready = (count != CW'(DEPTH));

`ifdef ALU_RESULT_FIFO_BYPASS_EN
    assign bypass = empty && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid && in_ready && !bypass;
    assign pop  = !empty && out_ready;

    // Outputs read as zero while empty so nothing stale leaks to the consumer.
    always_comb begin
        out_valid = 1'b0;
        out_r     = '0;
        out_flags = '0;
        if (!empty) begin
            out_valid = 1'b1;
            out_r     = r_mem[rd_ptr];
            out_flags = f_mem[rd_ptr];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_r     = in_r;
            out_flags = in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            r_mem[wr_ptr] <= in_r;
            f_mem[wr_ptr] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_push_full <= 1'b0;
        end else if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_push_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (in_valid && !in_ready) err_push_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized scoreboard bench for alu_result_fifo; reference model is a queue
// of expected entries plus an occupancy counter derived from the handshake rules.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_r;
    logic                   in_cout;
    logic                   in_ovr;
    logic [1:0]             in_op;
    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_r;
    logic [3:0]             out_flags;
    logic [$clog2(DEPTH):0] count;
    logic                   err_push_full;

    typedef struct {
        logic [3:0] r;
        logic [3:0] flags;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt;
    bit   model_err;
    bit   byp_mode;
    int   checks;
    int   errors;

    alu_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_r          (in_r),
        .in_cout       (in_cout),
        .in_ovr        (in_ovr),
        .in_op         (in_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_r         (out_r),
        .out_flags     (out_flags),
        .count         (count),
        .err_push_full (err_push_full)
    );

    always #5 clk = ~clk;

    // Flags straight from the arithmetic meaning: negative, zero, and carry/overflow only for add/sub.
    function automatic logic [3:0] ref_flags(logic [3:0] r, logic c, logic v, logic [1:0] op);
        bit arith = (op == 2'b00) || (op == 2'b01);
        bit n     = (r > 4'd7);
        bit z     = (r == 4'd0);
        return {n, z, arith && c, arith && v};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit bypass_now();
        return byp_mode && (model_cnt == 0) && in_valid && out_ready;
    endfunction

    // Scoreboard side: whenever the DUT shows a head entry, it must match the oldest expected one.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_out_valid: got 1, expected 0 at %0t", $time);
                end else begin
                    check("out_r", int'(out_r), int'(exp_q[0].r));
                    check("out_flags", int'(out_flags), int'(exp_q[0].flags));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic check_output();
        bit byp = bypass_now();
        check("count", int'(count), model_cnt);
        check("in_ready", int'(in_ready), int'(model_cnt != DEPTH));
        check("out_valid", int'(out_valid), int'((model_cnt != 0) || byp));
        check("err_push_full", int'(err_push_full), int'(model_err));
        if (model_cnt == 0 && !byp) begin
            check("empty_out_r", int'(out_r), 0);
            check("empty_out_flags", int'(out_flags), 0);
        end
    endtask

    // One clock of stimulus; called shortly after a rising edge, returns shortly after the next.
    task automatic apply_stimulus(input bit v, input logic [3:0] r, input bit c, input bit o,
                                  input logic [1:0] op, input bit rdy, input bit cl);
        bit do_push;
        bit do_pop;
        bit byp;
        check_output();
        in_valid  = v;
        in_r      = r;
        in_cout   = c;
        in_ovr    = o;
        in_op     = op;
        out_ready = cl ? 1'b0 : rdy;
        clr       = cl;
        byp       = bypass_now();
        do_push   = v && (model_cnt < DEPTH) && !byp && !cl;
        do_pop    = (model_cnt > 0) && out_ready && !cl;
        if ((do_push || byp) && !cl) exp_q.push_back('{r: r, flags: ref_flags(r, c, o, op)});
        @(posedge clk);
        if (cl) begin
            exp_q.delete();
            model_cnt = 0;
            model_err = 1'b0;
        end else begin
            if (v && model_cnt == DEPTH) model_err = 1'b1;
            model_cnt = model_cnt + int'(do_push) - int'(do_pop);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_r      = '0;
        in_cout   = 1'b0;
        in_ovr    = 1'b0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        clr       = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        model_err = 1'b0;
`ifdef ALU_RESULT_FIFO_BYPASS_EN
        byp_mode  = 1'b1;
`else
        byp_mode  = 1'b0;
`endif
        idle_inputs();
        rst_n = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(0, 4'h0, 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 4'h0, 1, 0, 2'b00, 0, 0);
        apply_stimulus(1, 4'h8, 1, 1, 2'b11, 0, 0);
        apply_stimulus(1, 4'h3, 1, 1, 2'b01, 0, 0);
        apply_stimulus(1, 4'hF, 0, 1, 2'b00, 0, 0);
        apply_stimulus(1, 4'h6, 1, 1, 2'b10, 0, 0);
        apply_stimulus(0, 4'h0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 4'h0, 0, 0, 2'b00, 1, 0);

        for (int i = 1; i <= 10; i++) apply_stimulus(1, 4'(i), i[0], i[1], 2'(i), 1, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 4'h0, 0, 0, 2'b00, 1, 0);

        for (int i = 0; i < 5; i++) apply_stimulus(1, 4'(i + 9), 1, 0, 2'b00, 0, 0);
        apply_stimulus(1, 4'h1, 0, 0, 2'b00, 1, 1);
        apply_stimulus(0, 4'h0, 0, 0, 2'b00, 0, 0);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus(bit'($urandom_range(0, 1)), 4'($urandom), bit'($urandom_range(0, 1)),
                           bit'($urandom_range(0, 1)), 2'($urandom), bit'($urandom_range(0, 2) != 0),
                           ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 3; i++) apply_stimulus(1, 4'(i + 4), 0, 1, 2'b01, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = 0;
        model_err = 1'b0;
        check("reset_count", int'(count), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        apply_stimulus(1, 4'h5, 0, 0, 2'b00, 0, 0);
        apply_stimulus(0, 4'h0, 0, 0, 2'b00, 1, 0);
        apply_stimulus(0, 4'h0, 0, 0, 2'b00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
